// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register-bank sequencer: opcodes, FSM states and
// default widths.
package reg_seq_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MOV = 3'b101,
    OP_LDI = 3'b110,
    OP_NOP = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_EXEC  = 2'b10,
    S_WRITE = 2'b11
  } state_t;

endpackage

// File: rtl/reg_sequencer_if.sv
// Instruction handshake plus the reg_bank port bundle seen by the sequencer.
interface reg_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 4
) ();

  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    opcode;
  logic [AW-1:0] rd;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [DW-1:0] imm;

  logic          rb_w_r;
  logic [AW-1:0] rb_w_add;
  logic [AW-1:0] rb_r_add_1;
  logic [AW-1:0] rb_r_add_2;
  logic [DW-1:0] rb_data;
  logic [DW-1:0] rb_data_1;
  logic [DW-1:0] rb_data_2;

  logic          done;
  logic [DW-1:0] result;
  logic          flag_z;
  logic          flag_c;

  // The sequencer side.
  modport slave (
    input  instr_valid, opcode, rd, rs1, rs2, imm, rb_data_1, rb_data_2,
    output instr_ready, rb_w_r, rb_w_add, rb_r_add_1, rb_r_add_2, rb_data,
           done, result, flag_z, flag_c
  );

  // The decode / reg_bank side.
  modport master (
    output instr_valid, opcode, rd, rs1, rs2, imm, rb_data_1, rb_data_2,
    input  instr_ready, rb_w_r, rb_w_add, rb_r_add_1, rb_r_add_2, rb_data,
           done, result, flag_z, flag_c
  );

endinterface

// File: rtl/reg_seq_alu.sv
// Combinational ALU for the sequencer; the parent decides whether its output
// is committed (NOP is never committed).
module reg_seq_alu
  import reg_seq_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  input  opcode_t       op,
  output logic [DW-1:0] result,
  output logic          z,
  output logic          c
);

  logic [DW:0] wide;

  // The extra top bit carries the ADD carry-out and the SUB borrow; logic ops leave it 0.
  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_MOV:  wide = {1'b0, a};
      OP_LDI:  wide = {1'b0, imm};
      default: wide = '0;
    endcase
  end

  assign result = wide[DW-1:0];
  assign c      = wide[DW];
  assign z      = (wide[DW-1:0] == '0);

endmodule

// File: rtl/reg_sequencer.sv
// Four-state register-bank initiator: accept, read operands, execute, write
// back. One instruction in flight, every output except instr_ready registered.
module reg_sequencer
  import reg_seq_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input logic           clk,
  input logic           rst,
  reg_sequencer_if.slave bus
);

  state_t        state;
  state_t        state_next;

  opcode_t       op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;

  logic          w_r_q;
  logic [AW-1:0] w_add_q;
  logic [AW-1:0] r_add_1_q;
  logic [AW-1:0] r_add_2_q;
  logic [DW-1:0] data_q;
  logic          done_q;
  logic [DW-1:0] result_q;
  logic          z_q;
  logic          c_q;

  logic [DW-1:0] alu_result;
  logic          alu_z;
  logic          alu_c;
  logic          accept;

  assign accept = bus.instr_valid && (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.instr_valid) state_next = S_READ;
      S_READ:  state_next = S_EXEC;
      S_EXEC:  state_next = S_WRITE;
      S_WRITE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  reg_seq_alu #(.DW(DW)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .op     (op_q),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c)
  );

  // Read addresses are loaded straight from the accepted fields so they are
  // already stable for the whole READ cycle; write-back strobes are armed at
  // the end of EXEC so rb_w_add/rb_data never move while rb_w_r is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_NOP;
      rd_q      <= '0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      w_r_q     <= 1'b0;
      w_add_q   <= '0;
      r_add_1_q <= '0;
      r_add_2_q <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q      <= opcode_t'(bus.opcode);
            rd_q      <= bus.rd;
            imm_q     <= bus.imm;
            r_add_1_q <= bus.rs1;
            r_add_2_q <= bus.rs2;
          end
        end
        S_READ: begin
          a_q <= bus.rb_data_1;
          b_q <= bus.rb_data_2;
        end
        S_EXEC: begin
          done_q <= 1'b1;
          if (op_q != OP_NOP) begin
            w_r_q    <= 1'b1;
            result_q <= alu_result;
            z_q      <= alu_z;
            c_q      <= alu_c;
            w_add_q  <= rd_q;
            data_q   <= alu_result;
          end
        end
        S_WRITE: begin
          w_r_q  <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          w_r_q  <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_ready = (state == S_IDLE);
  assign bus.rb_w_r      = w_r_q;
  assign bus.rb_w_add    = w_add_q;
  assign bus.rb_r_add_1  = r_add_1_q;
  assign bus.rb_r_add_2  = r_add_2_q;
  assign bus.rb_data     = data_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.flag_z      = z_q;
  assign bus.flag_c      = c_q;

endmodule

// File: tb/tb_reg_sequencer.sv
// Bench for reg_sequencer wired to a behavioural 16 x 8 reg_bank; table of
// instructions plus hand-written held-valid and reset-abort sequences.
module tb_reg_sequencer;
  import reg_seq_pkg::*;

  typedef struct {
    logic [2:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] imm;
    logic [7:0] exp_res;
    logic       exp_z;
    logic       exp_c;
    logic       exp_w;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   write_count;

  logic [7:0] bank     [16];
  logic [7:0] exp_bank [16];
  vec_t       vecs     [17];
  vec_t       held     [4];
  vec_t       one;

  reg_sequencer_if #(.DW(8), .AW(4)) bus ();

  reg_sequencer #(.DW(8), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural reg_bank: combinational reads, write while w_r is high at the clock.
  assign bus.rb_data_1 = bank[bus.rb_r_add_1];
  assign bus.rb_data_2 = bank[bus.rb_r_add_2];
  always @(posedge clk) begin
    if (bus.rb_w_r) bank[bus.rb_w_add] <= bus.rb_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_ready"},   32'(bus.instr_ready), 32'd1);
    check_output({tag, "_w_r"},     32'(bus.rb_w_r),      32'd0);
    check_output({tag, "_done"},    32'(bus.done),        32'd0);
    check_output({tag, "_z"},       32'(bus.flag_z),      32'd0);
    check_output({tag, "_c"},       32'(bus.flag_c),      32'd0);
    check_output({tag, "_w_add"},   32'(bus.rb_w_add),    32'd0);
    check_output({tag, "_r_add_1"}, 32'(bus.rb_r_add_1),  32'd0);
    check_output({tag, "_r_add_2"}, 32'(bus.rb_r_add_2),  32'd0);
    check_output({tag, "_data"},    32'(bus.rb_data),     32'd0);
    check_output({tag, "_result"},  32'(bus.result),      32'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.instr_ready) check_output("ready_timeout", 32'(bus.instr_ready), 32'd1);
  endtask

  task automatic drive_fields(input vec_t v);
    bus.opcode = v.op;
    bus.rd     = v.rd;
    bus.rs1    = v.rs1;
    bus.rs2    = v.rs2;
    bus.imm    = v.imm;
  endtask

  // Issues one instruction and checks it cycle by cycle through retirement.
  task automatic apply_stimulus(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    wait_ready();
    drive_fields(v);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.rd  = ~v.rd;
    bus.rs1 = ~v.rs1;
    bus.rs2 = ~v.rs2;
    bus.imm = ~v.imm;
    check_output({t, "_c1_ready"}, 32'(bus.instr_ready), 32'd0);
    check_output({t, "_c1_radd1"}, 32'(bus.rb_r_add_1),  32'(v.rs1));
    check_output({t, "_c1_radd2"}, 32'(bus.rb_r_add_2),  32'(v.rs2));
    check_output({t, "_c1_w_r"},   32'(bus.rb_w_r),      32'd0);
    check_output({t, "_c1_done"},  32'(bus.done),        32'd0);
    @(posedge clk);
    #1;
    check_output({t, "_c2_w_r"},   32'(bus.rb_w_r),      32'd0);
    check_output({t, "_c2_done"},  32'(bus.done),        32'd0);
    @(posedge clk);
    #1;
    check_output({t, "_c3_done"},  32'(bus.done),        32'd1);
    check_output({t, "_c3_w_r"},   32'(bus.rb_w_r),      32'(v.exp_w));
    check_output({t, "_result"},   32'(bus.result),      32'(v.exp_res));
    check_output({t, "_z"},        32'(bus.flag_z),      32'(v.exp_z));
    check_output({t, "_c"},        32'(bus.flag_c),      32'(v.exp_c));
    if (v.exp_w) begin
      check_output({t, "_w_add"},  32'(bus.rb_w_add),    32'(v.rd));
      check_output({t, "_data"},   32'(bus.rb_data),     32'(v.exp_res));
    end
    @(posedge clk);
    #1;
    check_output({t, "_c4_ready"}, 32'(bus.instr_ready), 32'd1);
    check_output({t, "_c4_done"},  32'(bus.done),        32'd0);
    check_output({t, "_c4_w_r"},   32'(bus.rb_w_r),      32'd0);
    if (v.exp_w) exp_bank[v.rd] = v.exp_res;
    check_output({t, "_bank"},     32'(bank[v.rd]),      32'(exp_bank[v.rd]));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 16; i++) exp_bank[i] = 8'h00;

    //             op      rd     rs1    rs2    imm    res    z     c     w
    vecs[0]  = '{OP_LDI, 4'd0,  4'd0,  4'd0,  8'h0A, 8'h0A, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{OP_MOV, 4'd1,  4'd0,  4'd0,  8'h00, 8'h0A, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{OP_LDI, 4'd2,  4'd0,  4'd0,  8'hF0, 8'hF0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{OP_LDI, 4'd3,  4'd0,  4'd0,  8'h20, 8'h20, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{OP_ADD, 4'd4,  4'd2,  4'd3,  8'h00, 8'h10, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{OP_LDI, 4'd5,  4'd0,  4'd0,  8'h05, 8'h05, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{OP_LDI, 4'd6,  4'd0,  4'd0,  8'h07, 8'h07, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{OP_SUB, 4'd7,  4'd5,  4'd6,  8'h00, 8'hFE, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{OP_XOR, 4'd7,  4'd7,  4'd7,  8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{OP_NOP, 4'd0,  4'd1,  4'd2,  8'h55, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{OP_AND, 4'd8,  4'd2,  4'd3,  8'h00, 8'h20, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{OP_OR,  4'd9,  4'd0,  4'd5,  8'h00, 8'h0F, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{OP_SUB, 4'd10, 4'd6,  4'd5,  8'h00, 8'h02, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{OP_ADD, 4'd11, 4'd3,  4'd3,  8'h00, 8'h40, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{OP_LDI, 4'd12, 4'd0,  4'd0,  8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{OP_SUB, 4'd13, 4'd0,  4'd0,  8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{OP_ADD, 4'd14, 4'd2,  4'd4,  8'h00, 8'h00, 1'b1, 1'b1, 1'b1};

    held[0]  = '{OP_LDI, 4'd15, 4'd0,  4'd0,  8'h33, 8'h33, 1'b0, 1'b0, 1'b1};
    held[1]  = '{OP_NOP, 4'd15, 4'd0,  4'd0,  8'h99, 8'h33, 1'b0, 1'b0, 1'b0};
    held[2]  = '{OP_MOV, 4'd14, 4'd15, 4'd0,  8'h00, 8'h33, 1'b0, 1'b0, 1'b1};
    held[3]  = '{OP_XOR, 4'd13, 4'd15, 4'd14, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};

    bus.instr_valid = 1'b0;
    drive_fields(vecs[0]);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) apply_stimulus(vecs[i], i);

    // Held valid: accepts on cycles 0/4/8/12, ready only on those cycles.
    $display("[TB] held-valid sequence");
    write_count = 0;
    wait_ready();
    drive_fields(held[0]);
    bus.instr_valid = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("held_c%0d_ready", c), 32'(bus.instr_ready), 32'((c % 4) == 0));
      check_output($sformatf("held_c%0d_done", c),  32'(bus.done),        32'((c % 4) == 3));
      if (bus.rb_w_r) write_count++;
      if ((c % 4) != 3)
        check_output($sformatf("held_c%0d_w_r", c), 32'(bus.rb_w_r), 32'd0);
      if ((c % 4) == 0 && c < 16) drive_fields(held[c / 4]);
      if (c == 16) bus.instr_valid = 1'b0;
    end
    check_output("held_writes", 32'(write_count), 32'd3);
    @(posedge clk);
    #1;
    check_output("held_no_extra_accept", 32'(bus.instr_ready), 32'd1);
    exp_bank[15] = 8'h33;
    exp_bank[14] = 8'h33;
    exp_bank[13] = 8'h00;
    check_output("held_r15", 32'(bank[15]), 32'h33);
    check_output("held_r14", 32'(bank[14]), 32'h33);
    check_output("held_r13", 32'(bank[13]), 32'h00);
    check_output("held_z",   32'(bus.flag_z), 32'd1);

    // Reset during EXEC of ADD r8 = r2 + r3.
    $display("[TB] reset during EXEC");
    one = '{OP_ADD, 4'd8, 4'd2, 4'd3, 8'h00, 8'h10, 1'b0, 1'b1, 1'b1};
    wait_ready();
    drive_fields(one);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_values("rst_exec");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check_output("rst_exec_no_w_r", 32'(bus.rb_w_r), 32'd0);
      check_output("rst_exec_no_done", 32'(bus.done), 32'd0);
    end
    check_output("rst_exec_r8", 32'(bank[8]), 32'(exp_bank[8]));

    // Reset during WRITE of the same instruction.
    $display("[TB] reset during WRITE");
    wait_ready();
    drive_fields(one);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_write_pre_w_r", 32'(bus.rb_w_r), 32'd1);
    rst = 1'b1;
    #1;
    check_output("rst_write_w_r_drop", 32'(bus.rb_w_r), 32'd0);
    check_reset_values("rst_write");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("rst_write_r8", 32'(bank[8]), 32'(exp_bank[8]));

    one = '{OP_MOV, 4'd8, 4'd5, 4'd0, 8'h00, 8'h05, 1'b0, 1'b0, 1'b1};
    apply_stimulus(one, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
